// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: coprocessor op encodings, register indices,
// exception codes and the control FSM state encoding.
package cp0_defs;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_MTC  = 3'd1,
      OP_MFC  = 3'd2,
      OP_ERET = 3'd3
   } cp_oper_e;

   localparam logic [4:0] IDX_EHBR   = 5'd3;
   localparam logic [4:0] IDX_STATUS = 5'd12;
   localparam logic [4:0] IDX_CAUSE  = 5'd13;
   localparam logic [4:0] IDX_EPC    = 5'd14;

   localparam logic [4:0] EXC_INT   = 5'd0;
   localparam logic [4:0] EXC_OOM   = 5'd4;
   localparam logic [4:0] EXC_UNDEF = 5'd10;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_HANDLER  = 2'd2
   } cp0_state_e;

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 signal bundle. The pipeline side is the master; CP0 is the slave.
interface cp0_unit_if;
   logic [2:0]  cp_oper;
   logic        id_valid;
   logic [4:0]  cp_addr;
   logic [31:0] cp_wdata;
   logic [31:0] cp_rdata;
   logic        undefined;
   logic        outOfMemory;
   logic        ir_in;
   logic [31:0] id_pc;
   logic [31:0] ex_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;

   modport master (
      output cp_oper, id_valid, cp_addr, cp_wdata, undefined, outOfMemory,
             ir_in, id_pc, ex_pc,
      input  cp_rdata, redirect, redirect_pc, in_handler
   );

   modport slave (
      input  cp_oper, id_valid, cp_addr, cp_wdata, undefined, outOfMemory,
             ir_in, id_pc, ex_pc,
      output cp_rdata, redirect, redirect_pc, in_handler
   );
endinterface

// File: rtl/cp0_regs.sv
// CP0 register file (EHBR, STATUS, CAUSE, EPC) with masked software writes,
// exception/eret side effects and a combinational read mux.
module cp0_regs
   import cp0_defs::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rd_addr_i,
   output logic [31:0] rd_data_o,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic        exc_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_epc_i,
   input  logic        eret_i,
   input  logic        dfault_i,
   output logic [31:0] ehbr_o,
   output logic [31:0] epc_o,
   output logic        ie_o
);

   logic [31:0] ehbr_q, ehbr_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  code_q, code_d;
   logic        ie_q, ie_d;
   logic        df_q, df_d;

   // The caller guarantees at most one of exc/eret/dfault/wr_en per cycle.
   always_comb begin
      ehbr_d = ehbr_q;
      epc_d  = epc_q;
      code_d = code_q;
      ie_d   = ie_q;
      df_d   = df_q;
      if (exc_i) begin
         epc_d  = exc_epc_i;
         code_d = exc_code_i;
         ie_d   = 1'b0;
      end else if (eret_i) begin
         ie_d = 1'b1;
      end else if (dfault_i) begin
         df_d = 1'b1;
      end else if (wr_en_i) begin
         case (wr_addr_i)
            IDX_EHBR:   ehbr_d = wr_data_i;
            IDX_STATUS: ie_d   = wr_data_i[0];
            IDX_CAUSE:  df_d   = wr_data_i[31];
            IDX_EPC:    epc_d  = wr_data_i;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ehbr_q <= '0;
         epc_q  <= '0;
         code_q <= '0;
         ie_q   <= 1'b0;
         df_q   <= 1'b0;
      end else begin
         ehbr_q <= ehbr_d;
         epc_q  <= epc_d;
         code_q <= code_d;
         ie_q   <= ie_d;
         df_q   <= df_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      case (rd_addr_i)
         IDX_EHBR:   rd_data_o = ehbr_q;
         IDX_STATUS: rd_data_o = {31'b0, ie_q};
         IDX_CAUSE:  rd_data_o = {df_q, 24'b0, code_q, 2'b00};
         IDX_EPC:    rd_data_o = epc_q;
         default:    rd_data_o = '0;
      endcase
   end

   assign ehbr_o = ehbr_q;
   assign epc_o  = epc_q;
   assign ie_o   = ie_q;

endmodule

// File: rtl/cp0_unit.sv
// CP0 control: exception/interrupt priority, interrupt edge latch and the
// NORMAL/REDIRECT/HANDLER sequencer that drives the fetch redirect.
module cp0_unit
   import cp0_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   cp0_unit_if.slave  bus,
   output cp0_state_e dbg_state_o
);

   cp0_state_e  state_q, state_d;
   logic        to_handler_q, to_handler_d;
   logic        ir_prev_q;
   logic        pending_q, pending_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic        ie;
   logic [31:0] ehbr, epc;
   logic        mtc_v, eret_v, undef_v, ir_rise;
   logic        exc_take, irq_take, eret_take, dfault, wr_en;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;

   assign mtc_v   = bus.id_valid && (bus.cp_oper == OP_MTC);
   assign eret_v  = bus.id_valid && (bus.cp_oper == OP_ERET);
   assign undef_v = bus.id_valid && bus.undefined;
   assign ir_rise = bus.ir_in && !ir_prev_q;

   always_comb begin
      state_d       = state_q;
      to_handler_d  = to_handler_q;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      exc_take      = 1'b0;
      irq_take      = 1'b0;
      eret_take     = 1'b0;
      dfault        = 1'b0;
      wr_en         = 1'b0;
      exc_code      = EXC_INT;
      exc_epc       = bus.id_pc;
      if (bus.outOfMemory) begin
         exc_code = EXC_OOM;
         exc_epc  = bus.ex_pc;
      end else if (undef_v) begin
         exc_code = EXC_UNDEF;
      end
      case (state_q)
         ST_NORMAL: begin
            exc_take = bus.outOfMemory || undef_v || (pending_q && ie);
            irq_take = exc_take && !bus.outOfMemory && !undef_v;
            if (exc_take) begin
               state_d       = ST_REDIRECT;
               to_handler_d  = 1'b1;
               redirect_d    = 1'b1;
               redirect_pc_d = ehbr;
            end else begin
               wr_en = mtc_v;
            end
         end
         // Pipeline is flushing: every ID/EX input is stale this cycle.
         ST_REDIRECT: state_d = to_handler_q ? ST_HANDLER : ST_NORMAL;
         ST_HANDLER: begin
            if (bus.outOfMemory || undef_v) begin
               dfault = 1'b1;
            end else if (eret_v) begin
               eret_take     = 1'b1;
               state_d       = ST_REDIRECT;
               to_handler_d  = 1'b0;
               redirect_d    = 1'b1;
               redirect_pc_d = epc;
            end else begin
               wr_en = mtc_v;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   assign pending_d = ir_rise || (pending_q && !irq_take);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_NORMAL;
         to_handler_q  <= 1'b0;
         ir_prev_q     <= 1'b0;
         pending_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         to_handler_q  <= to_handler_d;
         ir_prev_q     <= bus.ir_in;
         pending_q     <= pending_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   cp0_regs u_regs (
      .clk        (clk),
      .rst        (rst),
      .rd_addr_i  (bus.cp_addr),
      .rd_data_o  (bus.cp_rdata),
      .wr_en_i    (wr_en),
      .wr_addr_i  (bus.cp_addr),
      .wr_data_i  (bus.cp_wdata),
      .exc_i      (exc_take),
      .exc_code_i (exc_code),
      .exc_epc_i  (exc_epc),
      .eret_i     (eret_take),
      .dfault_i   (dfault),
      .ehbr_o     (ehbr),
      .epc_o      (epc),
      .ie_o       (ie)
   );

   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.in_handler  = (state_q == ST_HANDLER) ||
                            ((state_q == ST_REDIRECT) && to_handler_q);
   assign dbg_state_o     = state_q;

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 cp_oper  in  3  0=none, 1=mtc, 2=mfc, 3=eret; qualified by id_valid.
REQ-004 id_valid  in  1  ID-stage instruction is valid and not stalled this cycle.
REQ-005 cp_addr  in  5  CP0 register index (instruction rd field).
REQ-006 cp_wdata  in  32  GPR[rt] value for mtc.
REQ-007 cp_rdata  out  32  combinational read of register cp_addr (for mfc); 0 for unimplemented indices.
REQ-008 undefined  in  1  ID-stage undefined-instruction flag; qualified by id_valid.
REQ-009 outOfMemory  in  1  EX-stage load/store address out of range.
REQ-010 ir_in  in  1  external interrupt request, level, already synchronous to clk.
REQ-011 id_pc, ex_pc  in  32 each  PC of the ID-stage and EX-stage instructions.
REQ-012 redirect  out  1  one-cycle pulse: fetch from redirect_pc and flush IF/ID/EX.
REQ-013 redirect_pc  out  32  target when redirect=1; 0 otherwise.
REQ-014 in_handler  out  1  high while the exception handler runs.

Function
REQ-015 Registers: EHBR idx 3 (handler base), STATUS idx 12 (bit0 IE, other bits read 0), CAUSE idx 13 ([6:2] ExcCode, [31] double-fault sticky, others 0), EPC idx 14.
REQ-016 ExcCode values: interrupt=0, undefined=10, outOfMemory=4.
REQ-017 Interrupt pending latch: set on ir_in rising edge (ir_in=1 and previous-cycle ir_in=0); cleared when the interrupt is taken; level-held ir_in does not re-trigger.
REQ-018 States: NORMAL, REDIRECT, HANDLER; REDIRECT lasts exactly one cycle, then goes to HANDLER if entered by an exception, or NORMAL if entered by eret.
REQ-019 NORMAL, event priority: outOfMemory > (undefined & id_valid) > (pending & IE).
REQ-020 On taking an event: EPC <= ex_pc for outOfMemory, else id_pc; CAUSE.ExcCode <= code; IE <= 0; go to REDIRECT with redirect_pc = EHBR.
REQ-021 HANDLER: eret with id_valid: IE <= 1; go to REDIRECT with redirect_pc = EPC.
REQ-022 HANDLER: outOfMemory, or undefined with id_valid: CAUSE[31] <= 1; EPC, ExcCode and state unchanged; no redirect.
REQ-023 eret in NORMAL is a no-op.
REQ-024 mtc with id_valid, in NORMAL or HANDLER: write cp_wdata to cp_addr (STATUS takes only bit0; CAUSE takes only bit31, so software can clear the double-fault bit); writes to other indices are ignored.
REQ-025 When mtc and an event are taken in the same cycle, the event wins and the write is dropped.
REQ-026 REDIRECT: all cp_oper, undefined and outOfMemory inputs are ignored, because the pipeline is being flushed; the pending latch can still be set.
REQ-027 cp_rdata is a pure function of cp_addr and current register state; a same-cycle mtc is not bypassed.
REQ-028 redirect is registered: the event in cycle N produces redirect=1 in cycle N+1 only.
REQ-029 in_handler = 1 in HANDLER, and in REDIRECT when entered by an exception.

Reset
REQ-030 rst: state=NORMAL, EHBR=0, STATUS=0 (IE=0), CAUSE=0, EPC=0, pending=0, previous ir_in=0, redirect=0, redirect_pc=0, in_handler=0.
REQ-031 rst asserted mid-REDIRECT or mid-HANDLER aborts immediately to the reset values; no redirect pulse follows.

Structure
REQ-032 Shared package cp0_defs holds: cp_oper encodings, register indices 3/12/13/14, ExcCode constants, state encoding.
REQ-033 The register file (EHBR/STATUS/CAUSE/EPC with masked write and read mux) is one sub-module, cp0_regs; the FSM, priority logic and interrupt latch live in cp0_unit.

Verification
REQ-034 Sequence: mtc 3 <- 0x100, mtc 12 <- 1; undefined=1 with id_pc=0x40 -> next cycle redirect=1, redirect_pc=0x100; then EPC=0x40, ExcCode=10, IE=0, in_handler=1.
REQ-035 In HANDLER, eret with EPC=0x40 -> redirect=1, redirect_pc=0x40; IE=1; state NORMAL after one cycle.
REQ-036 IE=1, ir_in held high 10 cycles -> exactly one interrupt taken (ExcCode=0); after eret, no retrigger until ir_in falls and rises again.
REQ-037 Same cycle: outOfMemory=1 (ex_pc=0x20) and undefined=1 (id_pc=0x24) -> EPC=0x20, ExcCode=4.
REQ-038 In HANDLER, undefined=1 -> CAUSE=0x80000000|(ExcCode<<2), no redirect; then mtc 13 <- 0 clears bit31.
REQ-039 rst pulse during the REDIRECT cycle -> redirect=0 in the following cycles, all registers 0, state NORMAL.
